// File: rtl/design_sel_pkg.sv
// Shared types and constants for the design-select sequencer.
package design_sel_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        QUIESCE,
        SWITCH,
        HOLD
    } state_t;

    localparam int unsigned SEL_W_DEF  = 4;
    localparam int unsigned GPIO_W_DEF = 34;
    localparam int unsigned NO_DESIGN  = 0;

    // Bits needed for a counter running 0 .. max_cyc-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_cyc);
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/design_select_ctrl_sel_sync_filter.sv
// Two-flop synchronizer for the raw select plus a stability filter that
// only reports a candidate once it has been seen on STABLE_CYC consecutive cycles.
module sel_sync_filter
    import design_sel_pkg::*;
#(
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [SEL_W-1:0] sel_raw,
    output logic [SEL_W-1:0] candidate,
    output logic             stable
);

    localparam int unsigned CW = cnt_w(STABLE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [SEL_W-1:0] sel_meta;
    logic [SEL_W-1:0] sel_s;
    logic [CW-1:0]    stable_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_meta   <= '0;
            sel_s      <= '0;
            candidate  <= '0;
            stable_cnt <= '0;
        end else begin
            sel_meta <= sel_raw;
            sel_s    <= sel_meta;
            if (sel_s != candidate) begin
                candidate  <= sel_s;
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    assign stable = (stable_cnt == CNT_MAX);

endmodule

// File: rtl/design_select_ctrl.sv
// Safe design-select sequencer: quiesce pads, latch new select, hold reset, release.
// Optional macro DESIGN_SWITCH_COUNT_EN adds a saturating switch_count output.
module design_select_ctrl
    import design_sel_pkg::*;
#(
    parameter int unsigned SEL_W        = SEL_W_DEF,
    parameter int unsigned GPIO_W       = GPIO_W_DEF,
    parameter int unsigned STABLE_CYC   = 4,
    parameter int unsigned GUARD_CYC    = 8,
    parameter int unsigned RST_HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [SEL_W-1:0]  sel_raw,
    input  logic [GPIO_W-1:0] dsg_gpio_out,
    input  logic [GPIO_W-1:0] dsg_gpio_oeb,
    output logic [SEL_W-1:0]  design_select,
    output logic              design_n_rst,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb,
    output logic              busy
`ifdef DESIGN_SWITCH_COUNT_EN
    ,
    output logic [7:0]        switch_count
`endif
);

    localparam int unsigned CNT_W =
        cnt_w((GUARD_CYC > RST_HOLD_CYC) ? GUARD_CYC : RST_HOLD_CYC);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] guard_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [SEL_W-1:0] pending;
    logic [SEL_W-1:0] candidate;
    logic             stable;
    logic             req;
    logic             guard_done;
    logic             hold_done;
    logic             drive;

    sel_sync_filter #(
        .SEL_W      (SEL_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk       (clk),
        .n_rst     (n_rst),
        .sel_raw   (sel_raw),
        .candidate (candidate),
        .stable    (stable)
    );

    assign req        = stable && (candidate != design_select) && (state == ACTIVE);
    assign guard_done = (guard_cnt == CNT_W'(GUARD_CYC - 1));
    assign hold_done  = (hold_cnt == CNT_W'(RST_HOLD_CYC - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= HOLD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACTIVE:  if (req)        state_nxt = QUIESCE;
            QUIESCE: if (guard_done) state_nxt = SWITCH;
            SWITCH:                  state_nxt = HOLD;
            HOLD:    if (hold_done)  state_nxt = ACTIVE;
            default:                 state_nxt = HOLD;
        endcase
    end

    // pending is frozen at QUIESCE entry, so later select changes cannot abort a sequence
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            guard_cnt     <= '0;
            hold_cnt      <= '0;
            pending       <= '0;
            design_select <= '0;
            design_n_rst  <= 1'b0;
        end else begin
            unique case (state)
                ACTIVE: begin
                    if (req) begin
                        pending   <= candidate;
                        guard_cnt <= '0;
                    end
                end
                QUIESCE: begin
                    if (!guard_done) guard_cnt <= guard_cnt + CNT_W'(1);
                end
                SWITCH: begin
                    design_select <= pending;
                    design_n_rst  <= 1'b0;
                    hold_cnt      <= '0;
                end
                HOLD: begin
                    if (hold_done) design_n_rst <= 1'b1;
                    else           hold_cnt     <= hold_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ACTIVE);
        drive    = (state == ACTIVE) && (design_select != SEL_W'(NO_DESIGN));
        gpio_oeb = drive ? dsg_gpio_oeb : '1;
        gpio_out = drive ? dsg_gpio_out : '0;
    end

`ifdef DESIGN_SWITCH_COUNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                    switch_count <= '0;
        else if (state == SWITCH && switch_count != '1) switch_count <= switch_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_design_select_ctrl.sv
// Randomized bench for design_select_ctrl checked every cycle against a timeline model.
module tb_design_select_ctrl;

    localparam int SW = 4;
    localparam int GW = 34;
    localparam int S  = 4;
    localparam int G  = 8;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [SW-1:0] sel_raw;
    logic [GW-1:0] dsg_gpio_out;
    logic [GW-1:0] dsg_gpio_oeb;
    logic [SW-1:0] design_select;
    logic          design_n_rst;
    logic [GW-1:0] gpio_out;
    logic [GW-1:0] gpio_oeb;
    logic          busy;
`ifdef DESIGN_SWITCH_COUNT_EN
    logic [7:0]    switch_count;
`endif

    always #5 clk = ~clk;

    design_select_ctrl #(
        .SEL_W        (SW),
        .GPIO_W       (GW),
        .STABLE_CYC   (S),
        .GUARD_CYC    (G),
        .RST_HOLD_CYC (H)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .sel_raw       (sel_raw),
        .dsg_gpio_out  (dsg_gpio_out),
        .dsg_gpio_oeb  (dsg_gpio_oeb),
        .design_select (design_select),
        .design_n_rst  (design_n_rst),
        .gpio_out      (gpio_out),
        .gpio_oeb      (gpio_oeb),
        .busy          (busy)
`ifdef DESIGN_SWITCH_COUNT_EN
        ,
        .switch_count  (switch_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    bit model_ok = 1'b0;

    // Model: select seen through a 2-deep delay line; a value is accepted once
    // the last S synchronized samples agree. A sequence is a timeline m_t:
    // 0..G-1 guard, G switch, G+1..G+H reset hold, -1 idle.
    logic [SW-1:0] m_r1, m_r2, m_sel, m_pend;
    logic [SW-1:0] m_hist[$];
    int            m_t;
    bit            m_nrst;
    int            m_cnt;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_r1 = '0;
            m_r2 = '0;
            m_hist.delete();
            m_hist.push_back('0);
            m_sel  = '0;
            m_pend = '0;
            m_nrst = 1'b0;
            m_t    = G + 1;
            m_cnt  = 0;
            model_ok = 1'b1;
        end else begin
            logic [SW-1:0] cand;
            bit            st;
            cand = m_hist[$];
            st   = (m_hist.size() >= S);
            foreach (m_hist[i]) if (m_hist[i] != cand) st = 1'b0;
            if (m_t >= 0) begin
                if (m_t == G) begin
                    m_sel  = m_pend;
                    m_nrst = 1'b0;
                    if (m_cnt < 255) m_cnt++;
                end
                if (m_t == G + H) begin
                    m_nrst = 1'b1;
                    m_t    = -1;
                end else begin
                    m_t++;
                end
            end else if (st && cand != m_sel) begin
                m_pend = cand;
                m_t    = 0;
            end
            m_hist.push_back(m_r2);
            if (m_hist.size() > S) void'(m_hist.pop_front());
            m_r2 = m_r1;
            m_r1 = sel_raw;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic          drv;
            logic          exp_busy;
            logic [GW-1:0] exp_oeb, exp_out;
            exp_busy = (m_t >= 0);
            drv      = !exp_busy && (m_sel != '0);
            exp_oeb  = drv ? dsg_gpio_oeb : '1;
            exp_out  = drv ? dsg_gpio_out : '0;
            tests++;
            if (design_select !== m_sel || design_n_rst !== m_nrst || busy !== exp_busy ||
                gpio_oeb !== exp_oeb || gpio_out !== exp_out) begin
                fails++;
                $display("FAIL cycle_cmp @%0t: sel %h/%h nrst %b/%b busy %b/%b oeb %h/%h out %h/%h (got/expected)",
                         $time, design_select, m_sel, design_n_rst, m_nrst, busy, exp_busy,
                         gpio_oeb, exp_oeb, gpio_out, exp_out);
            end
`ifdef DESIGN_SWITCH_COUNT_EN
            tests++;
            if (switch_count !== 8'(m_cnt)) begin
                fails++;
                $display("FAIL switch_count_cmp @%0t: got %0d expected %0d", $time, switch_count, m_cnt);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_switch(input logic [SW-1:0] v);
        int n;
        sel_raw = v;
        n = 0;
        while (!(design_select === v && busy === 1'b0) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL switch_timeout: got select %0h expected %0h", design_select, v);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int            n;
        bit            seen;
        logic [SW-1:0] v;

        n_rst        = 1'b0;
        sel_raw      = '0;
        dsg_gpio_out = '0;
        dsg_gpio_oeb = '0;
        repeat (3) tick();
        n_rst = 1'b1;

        // Reset release with no design selected
        n = 0;
        while (design_n_rst === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        chk("rst_hold_len", 64'(n), 64'd4);
        chk("rst_select", 64'(design_select), 64'd0);
        chk("rst_busy_low", 64'(busy), 64'd0);
        chk("nodesign_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        repeat (5) tick();

        // 0 -> 3 switch
        dsg_gpio_oeb = '0;
        dsg_gpio_out = 34'h2_AAAA_AAAA;
        sel_raw      = 4'd3;
        n = 0;
        while (design_select !== 4'd3 && n < 100) begin
            tick();
            n++;
        end
        chk_rng("sel3_latency", n, 14, 16);
        chk("sel3_value", 64'(design_select), 64'd3);
        n = 0;
        while (design_n_rst === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        chk("sel3_rst_len", 64'(n), 64'd4);
        chk("sel3_busy", 64'(busy), 64'd0);
        chk("sel3_oeb", 64'(gpio_oeb), 64'd0);
        chk("sel3_out", 64'(gpio_out), 64'h2_AAAA_AAAA);
        repeat (10) tick();

        // Short glitch to 5 is filtered
        sel_raw = 4'd5;
        tick();
        tick();
        sel_raw = 4'd3;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("glitch_busy", 64'(seen), 64'd0);
        chk("glitch_select", 64'(design_select), 64'd3);

        // 3 -> 5, then 7 arrives during QUIESCE
        sel_raw = 4'd5;
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("quiesce_entered", 64'(busy), 64'd1);
        tick();
        tick();
        sel_raw = 4'd7;
        n = 0;
        while (design_select !== 4'd5 && n < 50) begin
            tick();
            n++;
        end
        chk("first_seq_sel", 64'(design_select), 64'd5);
        n = 0;
        while (design_select !== 4'd7 && n < 100) begin
            tick();
            n++;
        end
        chk("second_seq_sel", 64'(design_select), 64'd7);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("second_seq_idle", 64'(busy), 64'd0);

        // Reset asserted during HOLD of a 3 -> 5 switch
        do_switch(4'd3);
        sel_raw = 4'd5;
        n = 0;
        while (design_select !== 4'd5 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("hold_nrst_low", 64'(design_n_rst), 64'd0);
        sel_raw = 4'd0;
        n_rst   = 1'b0;
        #1;
        chk("midrst_select", 64'(design_select), 64'd0);
        chk("midrst_nrst", 64'(design_n_rst), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
        chk("midrst_out", 64'(gpio_out), 64'd0);
        tick();
        tick();
        n_rst = 1'b1;
        n = 0;
        while (design_n_rst === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        chk("midrst_hold_len", 64'(n), 64'd4);
        chk("midrst_after_sel", 64'(design_select), 64'd0);

        // Randomized segments, occasional reset pulses
        repeat (120) begin
            case ($urandom_range(0, 3))
                0:       v = 4'd0;
                1:       v = 4'd3;
                2:       v = 4'd5;
                default: v = 4'($urandom_range(0, 15));
            endcase
            sel_raw = v;
            repeat ($urandom_range(1, 40)) begin
                dsg_gpio_out = 34'({$urandom(), $urandom()});
                dsg_gpio_oeb = 34'({$urandom(), $urandom()});
                tick();
            end
            if ($urandom_range(0, 40) == 0) begin
                n_rst = 1'b0;
                tick();
                n_rst = 1'b1;
            end
        end

`ifdef DESIGN_SWITCH_COUNT_EN
        n_rst   = 1'b0;
        sel_raw = '0;
        tick();
        n_rst = 1'b1;
        do_switch(4'd0);
        for (int k = 0; k < 3; k++) do_switch((k % 2 == 0) ? 4'd3 : 4'd5);
        chk("count_three", 64'(switch_count), 64'd3);
        for (int k = 3; k < 300; k++) do_switch((k % 2 == 0) ? 4'd3 : 4'd5);
        chk("count_saturate", 64'(switch_count), 64'd255);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
